hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer.sv | 164 ++++++++++++++++
 tb/tb_hazard_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard detection and multi-cycle mul/div sequencing.
// Detects load-use and branch-operand hazards combinationally, stalls the front
// end, and walks a mul/div operation through start, wait and writeback drain.
// Optional build macro HAZARD_STALL_CNT_EN adds a saturating StallCount output.
module hazard_sequencer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] Rs_Id,
    input  logic [4:0] Rt_Id,
    input  logic [4:0] Rd_Ex,
    input  logic [4:0] Rd_Mem,
    input  logic       UsesRt_Id,
    input  logic       Branch_Id,
    input  logic       BranchTaken_Id,
    input  logic       MulDiv_Id,
    input  logic       MemRead_Ex,
    input  logic       RegWrite_Ex,
    input  logic       MemRead_Mem,
    input  logic       MulDivDone,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IDEXBubble,
    output logic       IFIDFlush,
    output logic       MulDivStart,
    output logic       MulDivWrite,
    output logic       MulDivErr
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0] StallCount
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MD_START = 2'd1;
    localparam logic [1:0] ST_MD_WAIT  = 2'd2;
    localparam logic [1:0] ST_MD_DRAIN = 2'd3;

    // Wait cycles allowed before the mul/div unit is declared hung.
    localparam logic [5:0] WAIT_LIMIT  = 6'd63;

    logic [1:0] state_q, state_d;
    logic [5:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;

    logic load_use, br_haz_ex, br_haz_mem, br_haz, hazard;
    logic pc_w, ifid_w, bubble, flush, md_start, md_write;

    // Hazard detection: purely combinational so the stall lands in the same cycle.
    always_comb begin
        load_use   = MemRead_Ex && (Rd_Ex != 5'd0) &&
                     ((Rd_Ex == Rs_Id) || (UsesRt_Id && (Rd_Ex == Rt_Id)));
        // Branches resolve in ID, so any in-flight producer of an operand blocks them;
        // a load stalls twice (EX then MEM), an ALU op only once (EX).
        br_haz_ex  = (RegWrite_Ex || MemRead_Ex) && (Rd_Ex != 5'd0) &&
                     ((Rd_Ex == Rs_Id) || (Rd_Ex == Rt_Id));
        br_haz_mem = MemRead_Mem && (Rd_Mem != 5'd0) &&
                     ((Rd_Mem == Rs_Id) || (Rd_Mem == Rt_Id));
        br_haz     = Branch_Id && (br_haz_ex || br_haz_mem);
        hazard     = load_use || br_haz;
    end

    // Sequencer next-state and raw pipeline controls.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        pc_w       = 1'b1;
        ifid_w     = 1'b1;
        bubble     = 1'b0;
        flush      = 1'b0;
        md_start   = 1'b0;
        md_write   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hazard) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    bubble = 1'b1;
                end else if (MulDiv_Id) begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    bubble  = 1'b1;
                    state_d = ST_MD_START;
                end else if (BranchTaken_Id) begin
                    flush = 1'b1;
                end
            end
            ST_MD_START: begin
                pc_w       = 1'b0;
                ifid_w     = 1'b0;
                bubble     = 1'b1;
                md_start   = 1'b1;
                wait_cnt_d = 6'd0;
                state_d    = ST_MD_WAIT;
            end
            ST_MD_WAIT: begin
                pc_w       = 1'b0;
                ifid_w     = 1'b0;
                bubble     = 1'b1;
                wait_cnt_d = wait_cnt_q + 6'd1;
                if (MulDivDone) begin
                    state_d = ST_MD_DRAIN;
                end else if (wait_cnt_d == WAIT_LIMIT) begin
                    // Hung unit: give up without writeback and flag it permanently.
                    err_d   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_MD_DRAIN: begin
                // Front end advances, but EX stays bubbled so the mul/div is not reissued.
                bubble   = 1'b1;
                md_write = 1'b1;
                state_d  = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Sequencer state, wait counter and sticky error flag.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 6'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Outputs are forced to the safe held/bubbled pattern for as long as reset is low.
    assign PCWrite     = Rst & pc_w;
    assign IFIDWrite   = Rst & ifid_w;
    assign IDEXBubble  = ~Rst | bubble;
    assign IFIDFlush   = Rst & flush;
    assign MulDivStart = Rst & md_start;
    assign MulDivWrite = Rst & md_write;
    assign MulDivErr   = err_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Next stall count: one per front-end-held cycle, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed and randomized bench for hazard_sequencer with a
// behavioural reference model of the stall/flush rules and the mul/div operation.
module tb_hazard_sequencer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst;
    logic [4:0] Rs_Id, Rt_Id, Rd_Ex, Rd_Mem;
    logic       UsesRt_Id, Branch_Id, BranchTaken_Id, MulDiv_Id;
    logic       MemRead_Ex, RegWrite_Ex, MemRead_Mem, MulDivDone;
    logic       PCWrite, IFIDWrite, IDEXBubble, IFIDFlush;
    logic       MulDivStart, MulDivWrite, MulDivErr;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] StallCount;
`endif

    hazard_sequencer dut (
        .Clk(Clk), .Rst(Rst),
        .Rs_Id(Rs_Id), .Rt_Id(Rt_Id), .Rd_Ex(Rd_Ex), .Rd_Mem(Rd_Mem),
        .UsesRt_Id(UsesRt_Id), .Branch_Id(Branch_Id), .BranchTaken_Id(BranchTaken_Id),
        .MulDiv_Id(MulDiv_Id), .MemRead_Ex(MemRead_Ex), .RegWrite_Ex(RegWrite_Ex),
        .MemRead_Mem(MemRead_Mem), .MulDivDone(MulDivDone),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
        .IFIDFlush(IFIDFlush), .MulDivStart(MulDivStart), .MulDivWrite(MulDivWrite),
        .MulDivErr(MulDivErr)
`ifdef HAZARD_STALL_CNT_EN
        , .StallCount(StallCount)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: where the outstanding mul/div op is (0 none, 1 about to
    // start, 2 waiting, 3 writing back), how many wait cycles it has spent, and
    // the sticky error and stall count.
    int op_stage = 0;
    int waited   = 0;
    bit err_m    = 1'b0;
    int stall_m  = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_hazard();
        bit lu, bex, bmem;
        lu   = MemRead_Ex && (Rd_Ex != 0) &&
               ((Rd_Ex == Rs_Id) || (UsesRt_Id && (Rd_Ex == Rt_Id)));
        bex  = (RegWrite_Ex || MemRead_Ex) && (Rd_Ex != 0) &&
               ((Rd_Ex == Rs_Id) || (Rd_Ex == Rt_Id));
        bmem = MemRead_Mem && (Rd_Mem != 0) && ((Rd_Mem == Rs_Id) || (Rd_Mem == Rt_Id));
        return lu || (Branch_Id && (bex || bmem));
    endfunction

    task automatic clear_inputs();
        Rs_Id = 0; Rt_Id = 0; Rd_Ex = 0; Rd_Mem = 0;
        UsesRt_Id = 0; Branch_Id = 0; BranchTaken_Id = 0; MulDiv_Id = 0;
        MemRead_Ex = 0; RegWrite_Ex = 0; MemRead_Mem = 0; MulDivDone = 0;
    endtask

    task automatic rand_inputs();
        Rs_Id = 5'($urandom_range(0, 7));
        Rt_Id = 5'($urandom_range(0, 7));
        Rd_Ex = 5'($urandom_range(0, 7));
        Rd_Mem = 5'($urandom_range(0, 7));
        UsesRt_Id = ($urandom_range(0, 1) == 0);
        Branch_Id = ($urandom_range(0, 2) == 0);
        BranchTaken_Id = ($urandom_range(0, 2) == 0);
        MulDiv_Id = ($urandom_range(0, 9) == 0);
        MemRead_Ex = ($urandom_range(0, 2) == 0);
        RegWrite_Ex = ($urandom_range(0, 1) == 0);
        MemRead_Mem = ($urandom_range(0, 2) == 0);
        MulDivDone = ($urandom_range(0, 5) == 0);
    endtask

    // Compare every output against the model for the current inputs, advance the
    // model across the coming rising edge, and return at the next falling edge.
    task automatic check_cycle(input string tag);
        bit haz;
        bit e_pc, e_ifid, e_bub, e_fl, e_st, e_wr;
        haz = 1'b0;
        #1;
        e_fl = 0; e_st = 0; e_wr = 0;
        if (!Rst) begin
            op_stage = 0; waited = 0; err_m = 0; stall_m = 0;
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else begin
            haz = ref_hazard();
            case (op_stage)
                1: begin e_pc = 0; e_ifid = 0; e_bub = 1; e_st = 1; end
                2: begin e_pc = 0; e_ifid = 0; e_bub = 1; end
                3: begin e_pc = 1; e_ifid = 1; e_bub = 1; e_wr = 1; end
                default: begin
                    if (haz || MulDiv_Id) begin
                        e_pc = 0; e_ifid = 0; e_bub = 1;
                    end else begin
                        e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = BranchTaken_Id;
                    end
                end
            endcase
        end
        chk({tag, ".PCWrite"}, PCWrite, e_pc);
        chk({tag, ".IFIDWrite"}, IFIDWrite, e_ifid);
        chk({tag, ".IDEXBubble"}, IDEXBubble, e_bub);
        chk({tag, ".IFIDFlush"}, IFIDFlush, e_fl);
        chk({tag, ".MulDivStart"}, MulDivStart, e_st);
        chk({tag, ".MulDivWrite"}, MulDivWrite, e_wr);
        chk({tag, ".MulDivErr"}, MulDivErr, err_m);
`ifdef HAZARD_STALL_CNT_EN
        chk_int({tag, ".StallCount"}, int'(StallCount), stall_m);
`endif
        if (Rst) begin
            if (!e_pc && stall_m != 65535) stall_m++;
            case (op_stage)
                0: if (!haz && MulDiv_Id) op_stage = 1;
                1: begin op_stage = 2; waited = 0; end
                2: begin
                    waited++;
                    if (MulDivDone) op_stage = 3;
                    else if (waited == 63) begin op_stage = 0; err_m = 1; end
                end
                default: op_stage = 0;
            endcase
        end
        @(negedge Clk);
    endtask

    initial begin
        int held, starts, writes, start_at, waits;
        bit seen, pc_at_err;

        clear_inputs();
        Rst = 1'b0;
        @(negedge Clk);
        check_cycle("reset0");
        check_cycle("reset1");
        Rst = 1'b1;
        check_cycle("idle");

        // Load-use: one stall, then the load sits in MEM and the consumer proceeds.
        clear_inputs(); MemRead_Ex = 1; Rd_Ex = 5; Rs_Id = 5;
        #1; chk("lu.stall_pc", PCWrite, 1'b0); chk("lu.stall_bub", IDEXBubble, 1'b1);
        check_cycle("lu0");
        clear_inputs(); Rs_Id = 5; MemRead_Mem = 1; Rd_Mem = 5;
        #1; chk("lu.go_pc", PCWrite, 1'b1);
        check_cycle("lu1");

        // Zero register never creates a hazard.
        clear_inputs(); MemRead_Ex = 1; Rd_Ex = 0; Rs_Id = 0;
        #1; chk("zero.pc", PCWrite, 1'b1);
        check_cycle("zero");

        // Branch after load: two stalls, then a taken branch flushes for one cycle.
        clear_inputs(); Branch_Id = 1; Rs_Id = 8; MemRead_Ex = 1; Rd_Ex = 8;
        #1; chk("brld.s0_pc", PCWrite, 1'b0);
        check_cycle("brld0");
        clear_inputs(); Branch_Id = 1; Rs_Id = 8; MemRead_Mem = 1; Rd_Mem = 8;
        #1; chk("brld.s1_pc", PCWrite, 1'b0);
        check_cycle("brld1");
        clear_inputs(); Branch_Id = 1; Rs_Id = 8; BranchTaken_Id = 1; Rd_Mem = 8;
        #1; chk("brld.flush", IFIDFlush, 1'b1); chk("brld.go_pc", PCWrite, 1'b1);
        check_cycle("brld2");
        clear_inputs();
        #1; chk("brld.noflush", IFIDFlush, 1'b0);
        check_cycle("brld3");

        // Branch after ALU producer: exactly one stall.
        clear_inputs(); Branch_Id = 1; Rt_Id = 3; RegWrite_Ex = 1; Rd_Ex = 3;
        #1; chk("bralu.s0_pc", PCWrite, 1'b0);
        check_cycle("bralu0");
        clear_inputs(); Branch_Id = 1; Rt_Id = 3; Rd_Mem = 3;
        #1; chk("bralu.go_pc", PCWrite, 1'b1);
        check_cycle("bralu1");

        // Mul/div with done ten cycles after start.
        clear_inputs(); MulDiv_Id = 1;
        held = 0; starts = 0; writes = 0; start_at = -1;
        for (int i = 0; i < 40 && writes == 0; i++) begin
            MulDivDone = (start_at >= 0 && i == start_at + 10);
            #1;
            if (!PCWrite) held++;
            if (MulDivStart) begin starts++; start_at = i; end
            if (MulDivWrite) writes++;
            check_cycle("md");
            MulDiv_Id = 0;
        end
        MulDivDone = 0;
        chk_int("md.held", held, 12);
        chk_int("md.starts", starts, 1);
        chk_int("md.writes", writes, 1);
        #1; chk("md.run_pc", PCWrite, 1'b1); chk("md.run_bub", IDEXBubble, 1'b0);
        check_cycle("md_after");

        // Timeout: done never arrives.
        clear_inputs(); MulDiv_Id = 1;
        seen = 0; waits = 0; writes = 0; starts = 0; pc_at_err = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            #1;
            if (MulDivErr) begin seen = 1; pc_at_err = PCWrite; end
            else if (starts > 0 && !PCWrite) waits++;
            if (MulDivStart) starts++;
            if (MulDivWrite) writes++;
            check_cycle("to");
            MulDiv_Id = 0;
        end
        chk("to.err_seen", seen, 1'b1);
        chk_int("to.waits", waits, 63);
        chk_int("to.writes", writes, 0);
        chk("to.run_pc", pc_at_err, 1'b1);

        // Randomized run (error remains sticky until the next reset).
        for (int i = 0; i < 150; i++) begin
            rand_inputs();
            #1; chk("rnd.excl", (int'(MulDivStart) + int'(MulDivWrite) + int'(IFIDFlush)) <= 1, 1'b1);
            check_cycle("rndA");
        end

        // Mid-operation reset while waiting, then a late done must be ignored.
        clear_inputs(); MulDiv_Id = 1;
        check_cycle("mr0");
        MulDiv_Id = 0;
        for (int i = 0; i < 5; i++) check_cycle("mr_wait");
        Rst = 1'b0;
        #1; chk("mr.start", MulDivStart, 1'b0); chk("mr.write", MulDivWrite, 1'b0);
        chk("mr.pc", PCWrite, 1'b0); chk("mr.bub", IDEXBubble, 1'b1); chk("mr.err", MulDivErr, 1'b0);
        check_cycle("mr_rst");
        Rst = 1'b1; MulDivDone = 1;
        #1; chk("mr.late_pc", PCWrite, 1'b1); chk("mr.late_write", MulDivWrite, 1'b0);
        check_cycle("mr_late");
        MulDivDone = 0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("mr.no_write", MulDivWrite, 1'b0);
            check_cycle("mr_after");
        end

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            #1; chk("rnd.excl", (int'(MulDivStart) + int'(MulDivWrite) + int'(IFIDFlush)) <= 1, 1'b1);
            check_cycle("rndB");
        end

        Rst = 1'b0; clear_inputs();
        check_cycle("reset_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
